// File: rtl/mbist_clk_gate_sequencer.sv
// Staggered, round-robin turn-on of MBIST clock-gate enables with per-gate release hold.
// Optional force-all-on input enabled by defining MBIST_CLK_GATE_SEQ_FORCE_EN.
module mbist_clk_gate_sequencer #(
   parameter int NUM_GATES = 4,
   parameter int STAGGER   = 2,
   parameter int HOLD      = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
`ifdef MBIST_CLK_GATE_SEQ_FORCE_EN
   input  logic                 force_on,
`endif
   input  logic [NUM_GATES-1:0] req,
   output logic [NUM_GATES-1:0] ack,
   output logic [NUM_GATES-1:0] gate_fe,
   output logic                 busy
);

   localparam int PW = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1;
   localparam int SW = $clog2(STAGGER + 1);
   localparam int HW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
   localparam logic [SW-1:0] STG_LOAD  = SW'(STAGGER - 1);
   localparam logic [HW-1:0] HOLD_LOAD = (HOLD > 0) ? HW'(HOLD - 1) : '0;
   localparam logic [PW-1:0] PTR_LAST  = PW'(NUM_GATES - 1);
   localparam logic [PW:0]   NUM_EXT   = (PW + 1)'(NUM_GATES);
   localparam logic          HOLD_EN   = (HOLD > 0) ? 1'b1 : 1'b0;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_PEND = 2'd1,
      ST_ON   = 2'd2,
      ST_HOLD = 2'd3
   } gate_state_e;

   gate_state_e          state_q    [NUM_GATES];
   gate_state_e          state_d    [NUM_GATES];
   logic [HW-1:0]        hold_cnt_q [NUM_GATES];
   logic [HW-1:0]        hold_cnt_d [NUM_GATES];
   logic [SW-1:0]        stg_q, stg_d;
   logic [PW-1:0]        ptr_q, ptr_d;
   logic [NUM_GATES-1:0] ack_q, ack_d;
   logic [NUM_GATES-1:0] fe_q, fe_d;
   logic                 busy_q, busy_d;

   logic [NUM_GATES-1:0] pend_s;
   logic [NUM_GATES-1:0] grant_s;
   logic                 grant_any_s;
   logic [PW-1:0]        grant_idx_s;
   logic [NUM_GATES-1:0] fsm_fe_s;
   logic [NUM_GATES-1:0] fsm_ack_s;
   logic                 force_s;

`ifdef MBIST_CLK_GATE_SEQ_FORCE_EN
   assign force_s = force_on;
`else
   assign force_s = 1'b0;
`endif

   // Round-robin pick of one still-requesting PEND gate, starting at the pointer.
   always_comb begin
      logic [PW:0]   sum;
      logic [PW-1:0] idx;
      sum         = '0;
      idx         = '0;
      pend_s      = '0;
      grant_s     = '0;
      grant_any_s = 1'b0;
      grant_idx_s = '0;
      for (int i = 0; i < NUM_GATES; i++) begin
         pend_s[i] = (state_q[i] == ST_PEND) && req[i];
      end
      if (stg_q == '0) begin
         for (int off = 0; off < NUM_GATES; off++) begin
            sum          = {1'b0, ptr_q} + (PW + 1)'(off);
            idx          = (sum >= NUM_EXT) ? PW'(sum - NUM_EXT) : PW'(sum);
            grant_s[idx] = !grant_any_s && pend_s[idx];
            grant_idx_s  = grant_s[idx] ? idx : grant_idx_s;
            grant_any_s  = grant_any_s | grant_s[idx];
         end
      end else begin
         grant_any_s = 1'b0;
      end
   end

   // Pointer and stagger spacing; turn-offs never touch the stagger counter.
   always_comb begin
      ptr_d = ptr_q;
      stg_d = stg_q;
      if (grant_any_s) begin
         ptr_d = (grant_idx_s == PTR_LAST) ? '0 : grant_idx_s + PW'(1);
         stg_d = STG_LOAD;
      end else if (stg_q != '0) begin
         stg_d = stg_q - SW'(1);
      end else begin
         stg_d = stg_q;
      end
   end

   // Per-gate OFF/PEND/ON/HOLD sequencing.
   always_comb begin
      for (int i = 0; i < NUM_GATES; i++) begin
         state_d[i]    = state_q[i];
         hold_cnt_d[i] = hold_cnt_q[i];
         case (state_q[i])
            ST_OFF: begin
               if (req[i]) begin
                  state_d[i] = ST_PEND;
               end else begin
                  state_d[i] = ST_OFF;
               end
            end
            ST_PEND: begin
               if (!req[i]) begin
                  state_d[i] = ST_OFF;
               end else if (grant_s[i]) begin
                  state_d[i] = ST_ON;
               end else begin
                  state_d[i] = ST_PEND;
               end
            end
            ST_ON: begin
               if (!req[i]) begin
                  state_d[i]    = HOLD_EN ? ST_HOLD : ST_OFF;
                  hold_cnt_d[i] = HOLD_LOAD;
               end else begin
                  state_d[i] = ST_ON;
               end
            end
            ST_HOLD: begin
               if (req[i]) begin
                  state_d[i] = ST_ON;
               end else if (hold_cnt_q[i] == '0) begin
                  state_d[i] = ST_OFF;
               end else begin
                  hold_cnt_d[i] = hold_cnt_q[i] - HW'(1);
               end
            end
            default: begin
               state_d[i]    = ST_OFF;
               hold_cnt_d[i] = '0;
            end
         endcase
      end
   end

   // Output next-state: ack only while the gate was already open and req still held.
   always_comb begin
      for (int i = 0; i < NUM_GATES; i++) begin
         fsm_fe_s[i]  = (state_d[i] == ST_ON) || (state_d[i] == ST_HOLD);
         fsm_ack_s[i] = req[i] && ((state_q[i] == ST_ON) || (state_q[i] == ST_HOLD));
      end
      if (force_s) begin
         fe_d  = '1;
         ack_d = req;
      end else begin
         fe_d  = fsm_fe_s;
         ack_d = fsm_ack_s;
      end
      busy_d = |fe_d;
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_GATES; i++) begin
            state_q[i]    <= ST_OFF;
            hold_cnt_q[i] <= '0;
         end
         stg_q  <= '0;
         ptr_q  <= '0;
         ack_q  <= '0;
         fe_q   <= '0;
         busy_q <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_GATES; i++) begin
            state_q[i]    <= state_d[i];
            hold_cnt_q[i] <= hold_cnt_d[i];
         end
         stg_q  <= stg_d;
         ptr_q  <= ptr_d;
         ack_q  <= ack_d;
         fe_q   <= fe_d;
         busy_q <= busy_d;
      end
   end

   assign ack     = ack_q;
   assign gate_fe = fe_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_mbist_clk_gate_sequencer.sv
// Self-checking bench: directed scenarios plus random req traffic against a
// behavioural model of the sequencer (pending set, open set, hold timers).
module tb_mbist_clk_gate_sequencer;
   localparam int N   = 4;
   localparam int STG = 2;
   localparam int HLD = 8;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] req   = '0;
   logic [N-1:0] ack;
   logic [N-1:0] gate_fe;
   logic         busy;
`ifdef MBIST_CLK_GATE_SEQ_FORCE_EN
   logic         force_on = 1'b0;
`endif

   always #5 clk = ~clk;

   mbist_clk_gate_sequencer #(.NUM_GATES(N), .STAGGER(STG), .HOLD(HLD)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
`ifdef MBIST_CLK_GATE_SEQ_FORCE_EN
      .force_on(force_on),
`endif
      .req     (req),
      .ack     (ack),
      .gate_fe (gate_fe),
      .busy    (busy)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Model: which gates wait for a slot, which are open, remaining hold time.
   bit           m_pend [N];
   bit           m_open [N];
   bit           m_ack  [N];
   int           m_hold [N];
   int           m_wait;
   int           m_next;
   logic [N-1:0] e_fe, e_ack;
   logic         e_busy;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         m_pend[i] = 1'b0;
         m_open[i] = 1'b0;
         m_ack[i]  = 1'b0;
         m_hold[i] = -1;
      end
      m_wait = 0;
      m_next = 0;
      e_fe   = '0;
      e_ack  = '0;
      e_busy = 1'b0;
   endfunction

   function automatic void model_step(input logic [N-1:0] r, input bit f);
      int winner;
      winner = -1;
      if (m_wait == 0) begin
         for (int k = 0; k < N; k++) begin
            int i;
            i = (m_next + k) % N;
            if (winner < 0 && m_pend[i] && r[i]) winner = i;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (m_pend[i]) begin
            m_ack[i] = 1'b0;
            if (!r[i]) m_pend[i] = 1'b0;
            else if (i == winner) begin
               m_pend[i] = 1'b0;
               m_open[i] = 1'b1;
               m_hold[i] = -1;
            end
         end else if (m_open[i] && m_hold[i] < 0) begin
            m_ack[i] = r[i];
            if (!r[i]) begin
               if (HLD == 0) m_open[i] = 1'b0;
               else m_hold[i] = HLD - 1;
            end
         end else if (m_open[i]) begin
            m_ack[i] = r[i];
            if (r[i]) m_hold[i] = -1;
            else if (m_hold[i] == 0) begin
               m_open[i] = 1'b0;
               m_hold[i] = -1;
            end else m_hold[i] = m_hold[i] - 1;
         end else begin
            m_ack[i]  = 1'b0;
            m_pend[i] = r[i];
         end
      end
      if (winner >= 0) begin
         m_wait = STG - 1;
         m_next = (winner + 1) % N;
      end else if (m_wait > 0) begin
         m_wait = m_wait - 1;
      end
      for (int i = 0; i < N; i++) begin
         e_fe[i]  = f ? 1'b1 : m_open[i];
         e_ack[i] = f ? r[i] : m_ack[i];
      end
      e_busy = |e_fe;
   endfunction

   task automatic cycle(input logic [N-1:0] r, input bit f);
      req = r;
`ifdef MBIST_CLK_GATE_SEQ_FORCE_EN
      force_on = f;
`endif
      @(posedge clk);
      if (rst_n) model_step(r, f);
      else model_reset();
      cyc++;
      @(negedge clk);
      check("gate_fe", 32'(gate_fe), 32'(e_fe));
      check("ack", 32'(ack), 32'(e_ack));
      check("busy", 32'(busy), 32'(e_busy));
      check("ack_without_fe", 32'(ack & ~gate_fe), 32'd0);
   endtask

   // Called right after cycle(): drops rst_n between edges and releases it later.
   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1;
      check("rst_fe", 32'(gate_fe), 32'd0);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      model_reset();
      cycle('0, 1'b0);
      cycle('0, 1'b0);
      rst_n = 1'b1;
      cyc = 0;
   endtask

   initial begin
      logic [N-1:0] r;
      bit           f;
      model_reset();
      cycle('0, 1'b0);
      cycle('0, 1'b0);
      rst_n = 1'b1;
      cyc = 0;

      // Single uncontended request, then release and hold.
      for (int k = 0; k < 10; k++) begin
         cycle(4'b0001, 1'b0);
         if (cyc == 1) check("t1_fe_c1", 32'(gate_fe), 32'h0);
         if (cyc == 2) check("t1_fe_c2", 32'(gate_fe), 32'h1);
         if (cyc == 2) check("t1_ack_c2", 32'(ack), 32'h0);
         if (cyc == 3) check("t1_ack_c3", 32'(ack), 32'h1);
      end
      for (int k = 0; k < 9; k++) begin
         cycle(4'b0000, 1'b0);
         if (cyc == 11) check("t1_ack_c11", 32'(ack), 32'h0);
         if (cyc == 11 || cyc == 18) check("t1_fe_hold", 32'(gate_fe), 32'h1);
         if (cyc == 19) check("t1_fe_c19", 32'(gate_fe), 32'h0);
      end

      // All four at once: staggered turn-on 0,1,2,3.
      async_reset();
      for (int k = 0; k < 10; k++) begin
         cycle(4'b1111, 1'b0);
         if (cyc == 2) check("t2_fe_c2", 32'(gate_fe), 32'h1);
         if (cyc == 3) check("t2_ack_c3", 32'(ack), 32'h1);
         if (cyc == 4) check("t2_fe_c4", 32'(gate_fe), 32'h3);
         if (cyc == 6) check("t2_fe_c6", 32'(gate_fe), 32'h7);
         if (cyc == 8) check("t2_fe_c8", 32'(gate_fe), 32'hf);
         if (cyc == 9) check("t2_ack_c9", 32'(ack), 32'hf);
      end

      // Reset with all gates open, then re-sequence from gate 0.
      async_reset();
      for (int k = 0; k < 10; k++) begin
         cycle(4'b1111, 1'b0);
         if (cyc == 2) check("t5_fe_c2", 32'(gate_fe), 32'h1);
      end

      // Re-request during hold keeps gate 1 open.
      for (int k = 0; k < 3; k++) begin
         cycle(4'b1101, 1'b0);
         check("t3_fe_hold", 32'(gate_fe), 32'hf);
      end
      cycle(4'b1111, 1'b0);
      check("t3_ack_back", 32'(ack), 32'hf);
      for (int k = 0; k < 12; k++) cycle(4'b0000, 1'b0);

      // Short pulse on req[2] while gate 0 is granted.
      cycle(4'b0001, 1'b0);
      cycle(4'b0101, 1'b0);
      cycle(4'b1001, 1'b0);
      check("t4_fe2_off", 32'(gate_fe[2]), 32'h0);
      cycle(4'b1001, 1'b0);
      check("t4_fe_gate3", 32'(gate_fe), 32'h9);
      for (int k = 0; k < 12; k++) cycle(4'b0000, 1'b0);

`ifdef MBIST_CLK_GATE_SEQ_FORCE_EN
      cycle(4'b0000, 1'b1);
      check("force_fe_on", 32'(gate_fe), 32'hf);
      check("force_ack", 32'(ack), 32'h0);
      cycle(4'b0000, 1'b0);
      check("force_fe_off", 32'(gate_fe), 32'h0);
`endif

      // Random traffic: slowly toggling request levels with occasional short pulses.
      r = '0;
      f = 1'b0;
      for (int k = 0; k < 600; k++) begin
         for (int b = 0; b < N; b++) begin
            if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
         end
`ifdef MBIST_CLK_GATE_SEQ_FORCE_EN
         if ($urandom_range(0, 19) == 0) f = ~f;
`endif
         cycle(r, f);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
